// File: rtl/trade_history_buffer.sv
// Circular trade-price history with oldest-first indexed read and a background min/max rescan.
// Read latency 1 cycle; min/max update atomically up to DEPTH+2 cycles after a write. Optional TRADE_HIST_FREEZE_EN adds a freeze input.
module trade_history_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              match_signal,
    input  logic [DATA_W-1:0] trade_price,
`ifdef TRADE_HIST_FREEZE_EN
    input  logic              freeze,
`endif
    input  logic [ADDR_W-1:0] rd_idx,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W:0]   count,
    output logic              wrapped,
    output logic [DATA_W-1:0] min_price,
    output logic [DATA_W-1:0] max_price,
    output logic              scan_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } scan_state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              wrapped_q, wrapped_d;
    logic              match_q;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;

    scan_state_t       state_q, state_d;
    logic [ADDR_W-1:0] s_idx_q, s_idx_d;
    logic [DATA_W-1:0] s_min_q, s_min_d;
    logic [DATA_W-1:0] s_max_q, s_max_d;
    logic [DATA_W-1:0] min_q, min_d;
    logic [DATA_W-1:0] max_q, max_d;

    logic              match_rise;
    logic              wr_en;
    logic              full;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] rd_phys;
    logic [ADDR_W-1:0] scan_phys;
    logic [DATA_W-1:0] scan_val;
    logic              scan_last;

    assign match_rise = match_signal & ~match_q;
`ifdef TRADE_HIST_FREEZE_EN
    assign wr_en = match_rise & ~freeze;
`else
    assign wr_en = match_rise;
`endif

    // Oldest valid entry sits count slots behind the write pointer; a full buffer wraps to wr_ptr itself.
    assign full      = (count_q == (ADDR_W+1)'(DEPTH));
    assign base      = wr_ptr_q - count_q[ADDR_W-1:0];
    assign rd_phys   = base + rd_idx;
    assign scan_phys = base + s_idx_q;
    assign scan_val  = mem[scan_phys];
    assign scan_last = ({1'b0, s_idx_q} == (count_q - 1'b1));

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= trade_price;
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        wrapped_d  = wrapped_q;
        rd_valid_d = ({1'b0, rd_idx} < count_q);
        rd_data_d  = rd_valid_d ? mem[rd_phys] : '0;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (full) begin
                wrapped_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            count_q    <= '0;
            wrapped_q  <= 1'b0;
            match_q    <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            wrapped_q  <= wrapped_d;
            match_q    <= match_signal;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // A write anywhere restarts the scan so the published window always matches a single count.
    always_comb begin
        state_d = state_q;
        s_idx_d = s_idx_q;
        s_min_d = s_min_q;
        s_max_d = s_max_q;
        min_d   = min_q;
        max_d   = max_q;
        case (state_q)
            S_IDLE: begin
                if (wr_en) begin
                    state_d = S_SCAN;
                    s_idx_d = '0;
                    s_min_d = '1;
                    s_max_d = '0;
                end
            end
            S_SCAN: begin
                if (wr_en) begin
                    s_idx_d = '0;
                    s_min_d = '1;
                    s_max_d = '0;
                end else begin
                    if (scan_val < s_min_q) s_min_d = scan_val;
                    if (scan_val > s_max_q) s_max_d = scan_val;
                    if (scan_last) begin
                        state_d = S_DONE;
                    end else begin
                        s_idx_d = s_idx_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                min_d = s_min_q;
                max_d = s_max_q;
                if (wr_en) begin
                    state_d = S_SCAN;
                    s_idx_d = '0;
                    s_min_d = '1;
                    s_max_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            s_idx_q <= '0;
            s_min_q <= '1;
            s_max_q <= '0;
            min_q   <= '0;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            s_idx_q <= s_idx_d;
            s_min_q <= s_min_d;
            s_max_q <= s_max_d;
            min_q   <= min_d;
            max_q   <= max_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign count     = count_q;
    assign wrapped   = wrapped_q;
    assign min_price = min_q;
    assign max_price = max_q;
    assign scan_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_trade_history_buffer.sv
// Bench for trade_history_buffer: read vectors from a table, reference history model, multi-cycle corner sequences.
module tb_trade_history_buffer;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    logic              clk;
    logic              reset;
    logic              match_signal;
    logic [DATA_W-1:0] trade_price;
    logic              freeze;
    logic [ADDR_W-1:0] rd_idx;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [ADDR_W:0]   count;
    logic              wrapped;
    logic [DATA_W-1:0] min_price;
    logic [DATA_W-1:0] max_price;
    logic              scan_busy;

    trade_history_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .match_signal (match_signal),
        .trade_price  (trade_price),
`ifdef TRADE_HIST_FREEZE_EN
        .freeze       (freeze),
`endif
        .rd_idx       (rd_idx),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .count        (count),
        .wrapped      (wrapped),
        .min_price    (min_price),
        .max_price    (max_price),
        .scan_busy    (scan_busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct packed {
        logic              v;
        logic [DATA_W-1:0] d;
    } rd_exp_t;

    typedef struct {
        logic [ADDR_W-1:0] idx;
        logic              ev;
        logic [DATA_W-1:0] ed;
    } vec_t;

    int      total = 0;
    int      bad   = 0;
    rd_exp_t sb[$];
    int      hist[$];
    logic    frozen = 1'b0;

    logic              mon_en = 1'b0;
    logic              partial_seen = 1'b0;
    logic [DATA_W-1:0] allow_min_a, allow_min_b, allow_max_a, allow_max_b;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int model_min();
        int m = 255;
        foreach (hist[i]) if (hist[i] < m) m = hist[i];
        return m;
    endfunction

    function automatic int model_max();
        int m = 0;
        foreach (hist[i]) if (hist[i] > m) m = hist[i];
        return m;
    endfunction

    task automatic reset_dut();
        reset = 1'b1;
        match_signal = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        hist.delete();
    endtask

    task automatic pulse(input int p);
        @(negedge clk);
        match_signal = 1'b1;
        trade_price  = DATA_W'(p);
        @(negedge clk);
        match_signal = 1'b0;
        if (!frozen) begin
            if (hist.size() == DEPTH) void'(hist.pop_front());
            hist.push_back(p);
        end
    endtask

    task automatic read_chk(input string nm, input logic [ADDR_W-1:0] idx, input logic ev, input logic [DATA_W-1:0] ed);
        rd_exp_t e;
        @(negedge clk);
        rd_idx = idx;
        sb.push_back({ev, ed});
        @(negedge clk);
        e = sb.pop_front();
        check({nm, "_valid"}, rd_valid, e.v);
        check({nm, "_data"}, rd_data, e.d);
    endtask

    task automatic wait_idle(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (scan_busy && lat < 300);
        if (scan_busy) check("scan_timeout", 1, 0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (!((min_price == allow_min_a || min_price == allow_min_b) &&
                  (max_price == allow_max_a || max_price == allow_max_b)))
                partial_seen <= 1'b1;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t tbl[5];
        int   lat;
        int   cnt_before;

        tbl[0] = '{idx: 6'd0, ev: 1'b1, ed: 8'd10};
        tbl[1] = '{idx: 6'd1, ev: 1'b1, ed: 8'd30};
        tbl[2] = '{idx: 6'd2, ev: 1'b1, ed: 8'd20};
        tbl[3] = '{idx: 6'd3, ev: 1'b1, ed: 8'd5};
        tbl[4] = '{idx: 6'd4, ev: 1'b0, ed: 8'd0};

        match_signal = 1'b0;
        trade_price  = '0;
        freeze       = 1'b0;
        rd_idx       = '0;
        reset_dut();

        check("rst_count", count, 0);
        check("rst_wrapped", wrapped, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_min", min_price, 0);
        check("rst_max", max_price, 0);
        check("rst_busy", scan_busy, 0);

        // Four trades, then table-driven reads
        pulse(10); pulse(30); pulse(20); pulse(5);
        check("four_count", count, hist.size());
        for (int i = 0; i < 5; i++) read_chk($sformatf("four_rd%0d", i), tbl[i].idx, tbl[i].ev, tbl[i].ed);
        wait_idle(lat);
        check("four_min", min_price, 5);
        check("four_max", max_price, 30);

        // Write during an active scan restarts it; no intermediate max may appear
        allow_min_a = 8'd5;  allow_min_b = 8'd5;
        allow_max_a = 8'd30; allow_max_b = 8'd200;
        partial_seen = 1'b0;
        mon_en = 1'b1;
        pulse(50);
        @(negedge clk);
        check("restart_busy", scan_busy, 1);
        pulse(200);
        wait_idle(lat);
        mon_en = 1'b0;
        check("restart_count", count, 6);
        check("restart_min", min_price, model_min());
        check("restart_max", max_price, 200);
        check("restart_no_partial", partial_seen, 0);

        // Level held high: one write only
        reset_dut();
        @(negedge clk);
        match_signal = 1'b1;
        trade_price  = 8'd42;
        repeat (200) @(negedge clk);
        match_signal = 1'b0;
        hist.push_back(42);
        check("hold_count", count, 1);
        wait_idle(lat);
        check("hold_min", min_price, 42);
        check("hold_max", max_price, 42);

        // Wrap-around
        reset_dut();
        for (int n = 0; n < 64; n++) pulse(n);
        check("full_count", count, 64);
        check("full_wrapped", wrapped, 0);
        for (int n = 64; n < 70; n++) pulse(n);
        wait_idle(lat);
        check("wrap_latency_le", (lat <= DEPTH + 2), 1);
        check("wrap_latency_ge", (lat >= DEPTH), 1);
        check("wrap_count", count, 64);
        check("wrap_wrapped", wrapped, 1);
        read_chk("wrap_rd0", 6'd0, 1'b1, 8'd6);
        read_chk("wrap_rd63", 6'd63, 1'b1, 8'd69);
        read_chk("wrap_rd31", 6'd31, 1'b1, DATA_W'(hist[31]));
        check("wrap_min", min_price, 6);
        check("wrap_max", max_price, 69);

        // Asynchronous reset in the middle of a scan
        reset_dut();
        for (int n = 0; n < 30; n++) pulse(100 + n);
        wait_idle(lat);
        pulse(3);
        repeat (5) @(negedge clk);
        check("midrst_busy_before", scan_busy, 1);
        check("midrst_count_before", count, 31);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("midrst_count", count, 0);
        check("midrst_min", min_price, 0);
        check("midrst_max", max_price, 0);
        check("midrst_busy", scan_busy, 0);
        check("midrst_wrapped", wrapped, 0);
        check("midrst_rd_valid", rd_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        hist.delete();
        pulse(7);
        check("midrst_next_count", count, 1);
        wait_idle(lat);
        check("midrst_next_min", min_price, 7);
        check("midrst_next_max", max_price, 7);

`ifdef TRADE_HIST_FREEZE_EN
        cnt_before = int'(count);
        freeze = 1'b1;
        frozen = 1'b1;
        pulse(90); pulse(91); pulse(92);
        check("freeze_count_held", count, cnt_before);
        freeze = 1'b0;
        frozen = 1'b0;
        pulse(93);
        check("freeze_count_resume", count, cnt_before + 1);
        wait_idle(lat);
        check("freeze_max", max_price, 93);
`else
        cnt_before = int'(count);
        pulse(93);
        check("nofreeze_count", count, cnt_before + 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
